// File: rtl/fifo_mw_pkg.sv
// Shared helpers for the multi-writer FIFO.
package fifo_mw_pkg;

    // Width needed to hold a lane rank or an accept count for n lanes (0..n).
    function automatic int rank_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_mw_lane_sel.sv
// Lane selector: prefix-counts the requesting lanes and grants the lowest
// ranked requesters that fit into the free space.
module fifo_mw_lane_sel
    import fifo_mw_pkg::*;
#(
    parameter int WR_NUM = 4,
    parameter int CNT_W  = 5,
    parameter int RANK_W = 3
) (
    input  logic [WR_NUM-1:0]             push,
    input  logic [CNT_W-1:0]              free,
    input  logic                          clr,
    output logic [WR_NUM-1:0][RANK_W-1:0] rank,
    output logic [WR_NUM-1:0]             accept,
    output logic [RANK_W-1:0]             n_acc
);

    logic [RANK_W-1:0] run;

    // Rank = requesters below this lane; a lane is granted while its rank
    // still fits in the slots free at the start of the cycle.
    always_comb begin
        run    = '0;
        n_acc  = '0;
        rank   = '0;
        accept = '0;
        for (int i = 0; i < WR_NUM; i++) begin
            rank[i]   = run;
            accept[i] = push[i] && !clr && (CNT_W'(run) < free);
            if (push[i])
                run = run + RANK_W'(1);
            if (accept[i])
                n_acc = n_acc + RANK_W'(1);
        end
    end

endmodule

// File: rtl/fifo_mw.sv
// Multi-writer, single-reader FIFO. Up to WR_NUM lanes push per cycle and
// are stored in ascending lane order; one registered read port drains it.
module fifo_mw
    import fifo_mw_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int WR_NUM     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Reset,
    input  logic [WR_NUM-1:0]            push,
    input  logic [DATA_WIDTH*WR_NUM-1:0] data_in,
    output logic [WR_NUM-1:0]            accept,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         empty,
    output logic                         full,
    output logic [ADDR_WIDTH:0]          count
);

    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int RANK_W = rank_width(WR_NUM);

    logic [ADDR_WIDTH-1:0]             wr_ptr, rd_ptr;
    logic [CNT_W-1:0]                  cnt;
    logic [DATA_WIDTH-1:0]             mem [RAM_DEPTH];
    logic [CNT_W-1:0]                  free;
    logic [WR_NUM-1:0][RANK_W-1:0]     rank;
    logic [RANK_W-1:0]                 n_acc;
    logic                              do_pop;

    assign free   = CNT_W'(RAM_DEPTH) - cnt;
    assign empty  = (cnt == '0);
    assign full   = (cnt == CNT_W'(RAM_DEPTH));
    assign count  = cnt;
    // A pop on an empty FIFO is dropped even if a write lands this cycle.
    assign do_pop = pop && !empty && !Reset;

    fifo_mw_lane_sel #(
        .WR_NUM (WR_NUM),
        .CNT_W  (CNT_W),
        .RANK_W (RANK_W)
    ) u_sel (
        .push   (push),
        .free   (free),
        .clr    (Reset),
        .rank   (rank),
        .accept (accept),
        .n_acc  (n_acc)
    );

    // Storage: each granted lane lands at wr_ptr + rank, wrapping naturally.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_NUM; i++) begin
            if (accept[i])
                mem[wr_ptr + ADDR_WIDTH'(rank[i])] <= data_in[DATA_WIDTH*i +: DATA_WIDTH];
        end
    end

    // Pointers and occupancy; the synchronous clear overrides traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(n_acc);
            if (do_pop)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            cnt <= cnt + CNT_W'(n_acc) - CNT_W'(do_pop);
        end
    end

    // Registered read data; holds across idle cycles and synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_out <= '0;
        else if (do_pop)
            data_out <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_fifo_mw.sv
// Directed bench for fifo_mw: a vector table for the basic flows plus
// hand-built sequences for wrap, near-full and clear corner cases.
module tb_fifo_mw;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         Reset;
    logic [3:0]   push;
    logic [255:0] data_in;
    logic [3:0]   accept;
    logic         pop;
    logic [63:0]  data_out;
    logic         empty, full;
    logic [4:0]   count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]       push;
        logic [3:0][63:0] d;
        logic             pop;
        logic             clr;
        logic [3:0]       acc;
        logic [4:0]       cnt;
        logic [63:0]      dout;
    } vec_t;

    vec_t tbl[$];

    fifo_mw #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .RAM_DEPTH(16), .WR_NUM(4)) dut (
        .clk(clk), .rst_n(rst_n), .Reset(Reset), .push(push), .data_in(data_in),
        .accept(accept), .pop(pop), .data_out(data_out), .empty(empty),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] p, input logic [63:0] d0, input logic [63:0] d1,
                                input logic [63:0] d2, input logic [63:0] d3, input logic pp,
                                input logic c, input logic [3:0] a, input logic [4:0] n,
                                input logic [63:0] o);
        vec_t v;
        v.push = p; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.pop = pp; v.clr = c; v.acc = a; v.cnt = n; v.dout = o;
        return v;
    endfunction

    // Entered #1 after a rising edge: drive, check accept, clock, check state.
    task automatic apply(input vec_t v, input string tag);
        push = v.push; data_in = v.d; pop = v.pop; Reset = v.clr;
        #2;
        chk({tag, ".accept"}, 64'(accept), 64'(v.acc));
        @(posedge clk); #1;
        chk({tag, ".count"}, 64'(count), 64'(v.cnt));
        chk({tag, ".empty"}, 64'(empty), 64'(v.cnt == 5'd0));
        chk({tag, ".full"},  64'(full),  64'(v.cnt == 5'd16));
        chk({tag, ".dout"},  data_out, v.dout);
        push = '0; pop = 1'b0; Reset = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; Reset = 1'b0; push = '0; pop = 1'b0; data_in = '0;
        #12;
        chk("rst.dout",   data_out, 64'h0);
        chk("rst.empty",  64'(empty), 64'h1);
        chk("rst.full",   64'(full), 64'h0);
        chk("rst.count",  64'(count), 64'h0);
        chk("rst.accept", 64'(accept), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single lane, all lanes, sparse lanes, pop-on-empty, clear
        tbl.push_back(mk(4'b0001, 'hA1, 0, 0, 0, 0, 0, 4'b0001, 1, 0));
        tbl.push_back(mk(4'b0001, 'hA2, 0, 0, 0, 0, 0, 4'b0001, 2, 0));
        tbl.push_back(mk(4'b0001, 'hA3, 0, 0, 0, 0, 0, 4'b0001, 3, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 2, 'hA1));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 'hA2));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 'hA3));
        tbl.push_back(mk(4'b1111, 'h10, 'h11, 'h12, 'h13, 0, 0, 4'b1111, 4, 'hA3));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 3, 'h10));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 2, 'h11));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 'h12));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 'h13));
        tbl.push_back(mk(4'b1010, 'hEE, 'h55, 'hEE, 'h77, 0, 0, 4'b1010, 2, 'h13));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 'h55));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 'h77));
        tbl.push_back(mk(4'b0001, 'h99, 0, 0, 0, 1, 0, 4'b0001, 1, 'h77));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 'h99));
        tbl.push_back(mk(4'b1111, 1, 2, 3, 4, 0, 1, 4'b0000, 0, 'h99));
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl%0d", i));

        // wrap: fill 14 from pointer 0, drain, then 4 lanes span mem[15]->mem[0]
        for (int k = 0; k < 3; k++)
            apply(mk(4'b1111, 'h20 + 4*k, 'h21 + 4*k, 'h22 + 4*k, 'h23 + 4*k, 0, 0,
                     4'b1111, 5'(4*k + 4), 'h99), $sformatf("wfill%0d", k));
        apply(mk(4'b0011, 'h2C, 'h2D, 0, 0, 0, 0, 4'b0011, 14, 'h99), "wfill3");
        for (int k = 0; k < 14; k++)
            apply(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 5'(13 - k), 64'('h20 + k)),
                  $sformatf("wdrain%0d", k));
        apply(mk(4'b1111, 'h30, 'h31, 'h32, 'h33, 0, 0, 4'b1111, 4, 'h2D), "wpush");
        for (int k = 0; k < 4; k++)
            apply(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 5'(3 - k), 64'('h30 + k)),
                  $sformatf("wpop%0d", k));

        // near full: 14 entries, then partial grant, then pop+push same cycle
        for (int k = 0; k < 3; k++)
            apply(mk(4'b1111, 'h50 + 4*k, 'h51 + 4*k, 'h52 + 4*k, 'h53 + 4*k, 0, 0,
                     4'b1111, 5'(4*k + 4), 'h33), $sformatf("nfill%0d", k));
        apply(mk(4'b0011, 'h5C, 'h5D, 0, 0, 0, 0, 4'b0011, 14, 'h33), "nfill3");
        apply(mk(4'b1111, 'h60, 'h61, 'h62, 'h63, 0, 0, 4'b0011, 16, 'h33), "npartial");
        apply(mk(4'b0001, 'h70, 0, 0, 0, 1, 0, 4'b0000, 15, 'h50), "npoppush");
        apply(mk(4'b0001, 'h70, 0, 0, 0, 0, 0, 4'b0001, 16, 'h50), "nrefill");

        // clear mid-operation: cnt=6, data_out=0x42, then Reset with pushes and pop
        apply(mk(4'b0000, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 'h50), "rclr0");
        apply(mk(4'b1111, 'h40, 'h41, 'h42, 'h43, 0, 0, 4'b1111, 4, 'h50), "rfill0");
        apply(mk(4'b1111, 'h44, 'h45, 'h46, 'h47, 0, 0, 4'b1111, 8, 'h50), "rfill1");
        apply(mk(4'b0001, 'h48, 0, 0, 0, 0, 0, 4'b0001, 9, 'h50), "rfill2");
        for (int k = 0; k < 3; k++)
            apply(mk(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 5'(8 - k), 64'('h40 + k)),
                  $sformatf("rpop%0d", k));
        apply(mk(4'b1111, 'hF0, 'hF1, 'hF2, 'hF3, 1, 1, 4'b0000, 0, 'h42), "rclr1");

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst.dout",  data_out, 64'h0);
        chk("arst.count", 64'(count), 64'h0);
        chk("arst.empty", 64'(empty), 64'h1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
